// File: rtl/top_bus_pkg.sv
// Shared FSM encoding and default read-window address bit for the microcontroller bus bridge.
package top_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ACT = 2'd1,
    RD_REQ = 2'd2,
    RD_CAP = 2'd3
  } state_t;

  localparam int WINDOW_BIT_DEF = 4;

endpackage

// File: rtl/top_sync.sv
// Width/depth parameterised synchronizer flop chain with a configurable reset value.
// Latency DEPTH clk cycles; no backpressure, samples every cycle.
module top_sync #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] chain_q;
  logic [DEPTH-1:0][W-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {DEPTH{RST_VAL}};
    else        chain_q <= chain_d;
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/top_bus_if.sv
// Asynchronous microcontroller bus to synchronous chip-logic bridge (ale/write/read strobes).
// Strobes appear SYNC_STAGES cycles after a raw edge; read data drives the bus SYNC_STAGES+2 cycles after read falls.
module top_bus_if
  import top_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW_BIT  = WINDOW_BIT_DEF
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic       ale,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] addr,
  output logic       wr_stb,
  output logic [7:0] wr_data,
  output logic       rd_stb,
  input  logic [7:0] rd_data,
  output logic       bus_err
);

  logic [2:0] ctl_s;
  logic [7:0] data_s;

  top_sync #(.W(3), .DEPTH(SYNC_STAGES), .RST_VAL(3'b111)) u_ctl_sync (
    .clk(osc), .rst_n(rst_n), .d({ale, write, read}), .q(ctl_s)
  );

  top_sync #(.W(8), .DEPTH(SYNC_STAGES), .RST_VAL(8'h00)) u_data_sync (
    .clk(osc), .rst_n(rst_n), .d(data_in), .q(data_s)
  );

  state_t     state_q, state_d;
  logic [2:0] ctl_p_q, ctl_p_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] data_out_q, data_out_d;
  logic       bus_err_q, bus_err_d;
  logic       hold_q, hold_d;
  logic [2:0] init_cnt_q, init_cnt_d;

  logic ale_s, wr_s, rd_s;
  logic ale_fall, ale_edge, wr_fall, wr_rise, rd_fall;
  logic init_done;

  assign ale_s     = ctl_s[2];
  assign wr_s      = ctl_s[1];
  assign rd_s      = ctl_s[0];
  assign ale_fall  = ~ale_s & ctl_p_q[2];
  assign ale_edge  = ale_s ^ ctl_p_q[2];
  assign wr_fall   = ~wr_s & ctl_p_q[1];
  assign wr_rise   = wr_s & ~ctl_p_q[1];
  assign rd_fall   = ~rd_s & ctl_p_q[0];
  assign init_done = (init_cnt_q == 3'(SYNC_STAGES));

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctl_p_q    <= 3'b111;
      addr_q     <= 8'h00;
      wr_data_q  <= 8'h00;
      data_out_q <= 8'h00;
      bus_err_q  <= 1'b0;
      hold_q     <= 1'b1;
      init_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      ctl_p_q    <= ctl_p_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      data_out_q <= data_out_d;
      bus_err_q  <= bus_err_d;
      hold_q     <= hold_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // hold_q blocks all edges until the chains have flushed reset values and both strobes are seen high.
  always_comb begin
    state_d    = state_q;
    ctl_p_d    = ctl_s;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    data_out_d = data_out_q;
    bus_err_d  = bus_err_q;
    hold_d     = hold_q;
    init_cnt_d = init_done ? init_cnt_q : init_cnt_q + 3'd1;

    if (hold_q) begin
      state_d = IDLE;
      if (init_done && wr_s && rd_s) hold_d = 1'b0;
    end else begin
      if (state_q != IDLE && ale_edge) bus_err_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (ale_fall) addr_d = data_s;
          if (!wr_s && !rd_s) begin
            bus_err_d = 1'b1;
            hold_d    = 1'b1;
          end else if (wr_fall) begin
            state_d = WR_ACT;
          end else if (rd_fall) begin
            state_d = RD_REQ;
          end
        end
        WR_ACT: begin
          if (rd_fall) begin
            bus_err_d = 1'b1;
            hold_d    = 1'b1;
            state_d   = IDLE;
          end else if (wr_rise) begin
            wr_data_d = data_s;
            state_d   = IDLE;
          end
        end
        RD_REQ: begin
          if (wr_fall) begin
            bus_err_d = 1'b1;
            hold_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            data_out_d = rd_data;
            state_d    = RD_CAP;
          end
        end
        RD_CAP: begin
          if (wr_fall) begin
            bus_err_d = 1'b1;
            hold_d    = 1'b1;
            state_d   = IDLE;
          end else if (rd_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are decoded from the current state, so wr_stb and rd_stb cannot coincide.
  always_comb begin
    wr_stb  = ~hold_q & (state_q == WR_ACT) & wr_rise & ~rd_fall;
    rd_stb  = ~hold_q & (state_q == IDLE) & rd_fall & wr_s;
    wr_data = wr_stb ? data_s : wr_data_q;
    data_oe = ~read & addr_q[WINDOW_BIT] & (state_q == RD_CAP);
  end

  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign bus_err  = bus_err_q;

endmodule

// File: doc/top_bus_if.md
TOP_BUS_IF -- requirements
Module: top_bus_if

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for ale/write/read and the data sample path (legal 2..4).
REQ-002 The block SHALL have parameter WINDOW_BIT, default 4, the address bit that enables the data-bus read driver.
REQ-003 osc  in  1  12 MHz clock (post-IBUF), the single clock of the block.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ale  in  1  microcontroller address-latch enable, asynchronous; a falling edge latches the address.
REQ-006 write  in  1  microcontroller write strobe, active-low, asynchronous; a rising edge completes a write.
REQ-007 read  in  1  microcontroller read strobe, active-low, asynchronous.
REQ-008 data_in  in  8  microcontroller data-bus input side.
REQ-009 data_out  out  8  data-bus drive value (registered read data).
REQ-010 data_oe  out  1  data-bus output enable, high drives the bus.
REQ-011 addr  out  8  latched address.
REQ-012 wr_stb  out  1  one-cycle write pulse to the chip logic.
REQ-013 wr_data  out  8  write data, valid while wr_stb is high and held afterwards.
REQ-014 rd_stb  out  1  one-cycle read request to the chip logic.
REQ-015 rd_data  in  8  chip-logic read data, valid exactly one osc cycle after rd_stb.
REQ-016 bus_err  out  1  sticky protocol-error flag.

Function
REQ-017 ale, write and read SHALL each pass through a SYNC_STAGES flop chain; data_in SHALL pass through an equal-depth chain so each sampled byte aligns with its control edge.
REQ-018 Edge detection SHALL compare the last two synchronized samples; each edge SHALL be acted on exactly once.
REQ-019 FSM states: IDLE, WR_ACT, RD_REQ, RD_CAP; only IDLE accepts ale edges.
REQ-020 In IDLE, a synchronized ale falling edge SHALL load addr from the aligned data sample in the same cycle the edge is detected.
REQ-021 In IDLE, a synchronized write falling edge SHALL move to WR_ACT; the synchronized rising edge SHALL load wr_data from the aligned sample, pulse wr_stb for one cycle, and return to IDLE.
REQ-022 In IDLE, a synchronized read falling edge SHALL pulse rd_stb for one cycle with addr stable and move to RD_REQ; RD_REQ SHALL move to RD_CAP, where data_out is loaded from rd_data, and RD_CAP SHALL hold until the synchronized read rises, then return to IDLE.
REQ-023 Read latency from the raw read falling edge to valid data_out SHALL be at most SYNC_STAGES+3 osc cycles (417 ns at the default depth); the microcontroller read pulse SHALL be at least that long.
REQ-024 data_oe SHALL be (raw read low) AND addr[WINDOW_BIT] AND (state is RD_CAP), driving only after valid data is captured and releasing combinationally on read rising.
REQ-025 If read and write are both synchronized-low in IDLE, or either strobe falls while not in IDLE, the block SHALL set bus_err, issue no strobe for that access, and return to IDLE once both strobes are high.
REQ-026 A synchronized ale edge outside IDLE SHALL be ignored and SHALL set bus_err.
REQ-027 bus_err SHALL clear only on reset.
REQ-028 wr_stb and rd_stb SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE; addr, wr_data and data_out 0x00; wr_stb, rd_stb, data_oe and bus_err 0; synchronizer chains for ale, write and read 1 (idle-high); data chains 0x00.
REQ-030 Reset during an access SHALL abandon it with no strobe issued; after release, a strobe already low SHALL NOT generate an edge until it returns high.

Structure
REQ-031 The FSM state encoding and the WINDOW_BIT default SHALL be defined in shared package top_bus_pkg.
REQ-032 A single sub-module top_sync (parameterised width/depth flop chain with reset value) SHALL implement all synchronizers.

Verification
REQ-033 ale pulse with data 0x12, then write low/high with data 0xA5 -> addr=0x12; one wr_stb with wr_data=0xA5; bus_err=0.
REQ-034 addr 0x10, read low for 8 cycles, rd_data=0x3C the cycle after rd_stb -> one rd_stb; data_oe high by cycle SYNC_STAGES+3; data_out=0x3C; data_oe drops with read.
REQ-035 addr 0x05, read cycle -> rd_stb pulses; data_oe stays 0 throughout.
REQ-036 read and write driven low together -> no wr_stb/rd_stb; bus_err=1 until rst_n pulse.
REQ-037 rst_n asserted mid-read (state RD_CAP) -> data_oe=0 immediately; all outputs at reset values; no rd_stb after release until read cycles high then low.
REQ-038 Strobe glitch shorter than one osc period, not sampled -> no strobe, no state change.
